// File: rtl/reg_resto_pkg.sv
// Shared definitions for the remainder FIFO: pointer/level widths,
// reset values of registered status and the default level type.
package reg_resto_pkg;

  localparam int DEPTH_DEF = 4;

  localparam logic RST_FIM     = 1'b0;
  localparam logic RST_ESTOURO = 1'b0;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int nivel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [nivel_width(DEPTH_DEF)-1:0] nivel_t;

endpackage

// File: rtl/reg_resto_mem.sv
// DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous read port; storage is intentionally left unreset.
module reg_resto_mem
  import reg_resto_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/reg_resto_fila.sv
// Show-ahead remainder FIFO with valid/ack read side and sticky overflow.
// Optional REG_RESTO_ZERO_EN adds restoZero, a per-entry exact-division flag.
module reg_resto_fila
  import reg_resto_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetResto,
  input  logic [WIDTH-1:0]              entrada,
  input  logic                          EnResto,
  input  logic                          lidoResto,
  output logic [WIDTH-1:0]              saidaResto,
  output logic                          validResto,
  output logic                          FimResto,
  output logic                          cheio,
  output logic                          vazio,
  output logic [nivel_width(DEPTH)-1:0] nivel,
  output logic                          estouro,
  input  logic                          limpaEstouro
`ifdef REG_RESTO_ZERO_EN
  ,
  output logic                          restoZero
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int NW = nivel_width(DEPTH);
`ifdef REG_RESTO_ZERO_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [NW-1:0] r_nivel;
  logic          r_fim;
  logic          r_estouro;

  logic          w_pop;
  logic          w_push;
  logic          w_ovf;
  logic [MW-1:0] w_wdata;
  logic [MW-1:0] w_rdata;

  assign vazio      = (r_nivel == NW'(0));
  assign cheio      = (r_nivel == NW'(DEPTH));
  assign validResto = ~vazio;
  assign nivel      = r_nivel;
  assign FimResto   = r_fim;
  assign estouro    = r_estouro;

  // A pop in the same cycle frees a slot, so a push is legal even when full.
  assign w_pop  = lidoResto & validResto;
  assign w_push = EnResto & (~cheio | w_pop);
  assign w_ovf  = EnResto & cheio & ~w_pop;

`ifdef REG_RESTO_ZERO_EN
  assign w_wdata    = {(entrada == WIDTH'(0)), entrada};
  assign restoZero  = validResto & w_rdata[WIDTH];
`else
  assign w_wdata    = entrada;
`endif
  assign saidaResto = validResto ? w_rdata[WIDTH-1:0] : WIDTH'(0);

  reg_resto_mem #(
    .WIDTH (MW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (w_push & ~resetResto),
    .waddr (r_tail),
    .wdata (w_wdata),
    .raddr (r_head),
    .rdata (w_rdata)
  );

  // Pointer, level and status registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (resetResto) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_nivel   <= '0;
      r_fim     <= RST_FIM;
      r_estouro <= RST_ESTOURO;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_nivel <= r_nivel + NW'(1);
      end else if (w_pop && !w_push) begin
        r_nivel <= r_nivel - NW'(1);
      end
      r_fim <= w_push;
      if (w_ovf) begin
        r_estouro <= 1'b1;
      end else if (limpaEstouro) begin
        r_estouro <= 1'b0;
      end
    end
  end

endmodule
